// File: rtl/best_neighbor_scan_pkg.sv
// Shared memory map and scan FSM encoding for the neighbor table.
// Used by the best-neighbor scanner and by the memory map that hosts the lists.
package best_neighbor_scan_pkg;

  localparam int BN_ADDR_W   = 11;
  localparam int BN_DATA_W   = 16;
  localparam int BN_IDX_W    = 6;

  // Byte addresses of the neighbor lists in the shared word memory.
  localparam logic [10:0] BN_ID_BASE    = 11'h048;
  localparam logic [10:0] BN_QVAL_BASE  = 11'h1C8;
  localparam logic [10:0] BN_COUNT_ADDR = 11'h68A;

  // Capacity of each list, in 16-bit entries.
  localparam int BN_ID_LIST_LEN   = 64;
  localparam int BN_QVAL_LIST_LEN = 64;
  localparam int BN_MAX_ENTRIES   = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_CNT = 3'd1,
    RD_Q   = 3'd2,
    RD_ID  = 3'd3,
    DONE   = 3'd4
  } bn_state_e;

  // Byte address of 16-bit entry idx in the list starting at base, modulo 2048.
  function automatic logic [10:0] entry_addr(input logic [10:0] base,
                                             input logic [5:0]  idx);
    return base + {4'b0000, idx, 1'b0};
  endfunction

endpackage

// File: rtl/best_neighbor_scan.sv
// Scans the neighbor table and reports the entry with the largest qValue.
// Reads neighborCount, then for each entry its qValue and neighborID; the
// earliest entry wins on equal qValues. The memory read is combinational, so
// the address is registered from the next state and mem_data is consumed in
// the cycle the address is presented.
module best_neighbor_scan
  import best_neighbor_scan_pkg::*;
#(
  parameter logic [10:0] COUNT_ADDR  = BN_COUNT_ADDR,
  parameter logic [10:0] QVAL_BASE   = BN_QVAL_BASE,
  parameter logic [10:0] ID_BASE     = BN_ID_BASE,
  parameter int          MAX_ENTRIES = BN_MAX_ENTRIES
) (
  input  logic        clock,
  input  logic        nrst,
  input  logic        start,
  input  logic [15:0] mem_data,
  output logic [10:0] mem_address,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [15:0] best_id,
  output logic [15:0] best_q,
  output logic [5:0]  best_idx
);

  bn_state_e   state_q, state_d;
  logic [5:0]  i_q, i_d;
  logic [6:0]  n_q, n_d;
  logic [15:0] q_cur_q, q_cur_d;
  logic [15:0] best_q_q, best_q_d;
  logic [15:0] best_id_q, best_id_d;
  logic [5:0]  best_idx_q, best_idx_d;
  logic        found_q, found_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [10:0] addr_q, addr_d;

  // Next-state, datapath and next read address.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    n_d        = n_q;
    q_cur_d    = q_cur_q;
    best_q_d   = best_q_q;
    best_id_d  = best_id_q;
    best_idx_d = best_idx_q;
    found_d    = found_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    addr_d     = COUNT_ADDR;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RD_CNT;
          best_q_d   = 16'h0000;
          best_id_d  = 16'h0000;
          best_idx_d = 6'd0;
          found_d    = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RD_CNT: begin
        if (mem_data > 16'(MAX_ENTRIES)) begin
          n_d = 7'(MAX_ENTRIES);
        end else begin
          n_d = mem_data[6:0];
        end
        i_d = 6'd0;
        if (n_d == 7'd0) begin
          state_d = DONE;
        end else begin
          state_d = RD_Q;
        end
      end
      RD_Q: begin
        q_cur_d = mem_data;
        state_d = RD_ID;
      end
      RD_ID: begin
        // Strict compare keeps the earliest index on ties.
        if ((i_q == 6'd0) || (q_cur_q > best_q_q)) begin
          best_q_d   = q_cur_q;
          best_id_d  = mem_data;
          best_idx_d = i_q;
        end else begin
          best_q_d   = best_q_q;
        end
        i_d = i_q + 6'd1;
        if (({1'b0, i_q} + 7'd1) == n_q) begin
          state_d = DONE;
        end else begin
          state_d = RD_Q;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        found_d = (n_q != 7'd0);
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    case (state_d)
      RD_Q:    addr_d = entry_addr(QVAL_BASE, i_d);
      RD_ID:   addr_d = entry_addr(ID_BASE, i_d);
      default: addr_d = COUNT_ADDR;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      i_q        <= 6'd0;
      n_q        <= 7'd0;
      q_cur_q    <= 16'h0000;
      best_q_q   <= 16'h0000;
      best_id_q  <= 16'h0000;
      best_idx_q <= 6'd0;
      found_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= COUNT_ADDR;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      n_q        <= n_d;
      q_cur_q    <= q_cur_d;
      best_q_q   <= best_q_d;
      best_id_q  <= best_id_d;
      best_idx_q <= best_idx_d;
      found_q    <= found_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      addr_q     <= addr_d;
    end
  end

  assign mem_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign best_id     = best_id_q;
  assign best_q      = best_q_q;
  assign best_idx    = best_idx_q;

endmodule

// File: doc/best_neighbor_scan.md
BEST_NEIGHBOR_SCAN -- requirements
Module: best_neighbor_scan

Interface
REQ-001 Parameter COUNT_ADDR, default 11'h68A, byte address of the neighborCount word.
REQ-002 Parameter QVAL_BASE, default 11'h1C8, byte address of qValue entry 0.
REQ-003 Parameter ID_BASE, default 11'h48, byte address of neighborID entry 0.
REQ-004 Parameter MAX_ENTRIES, default 64, maximum number of entries scanned.
REQ-005 One clock; reset is asynchronous and active-low; ports are named clock and nrst.
REQ-006 clock  input  1  rising-edge clock shared with the word memory.
REQ-007 nrst  input  1  asynchronous active-low reset.
REQ-008 start  input  1  one-cycle scan request.
REQ-009 mem_data  input  16  word read from memory at mem_address, valid in the same cycle (combinational read).
REQ-010 mem_address  output  11  byte address driven to the memory read port.
REQ-011 busy  output  1  high from the accepted start until done.
REQ-012 done  output  1  one-cycle pulse at scan completion.
REQ-013 found  output  1  high when the completed scan had at least one entry.
REQ-014 best_id  output  16  neighborID of the maximum qValue.
REQ-015 best_q  output  16  maximum qValue, unsigned.
REQ-016 best_idx  output  6  entry index of the maximum.

Function
REQ-017 The FSM SHALL have states IDLE, RD_CNT, RD_Q, RD_ID and DONE.
REQ-018 In IDLE, start=1 SHALL move to RD_CNT, clear best_q, best_id, best_idx and found, and raise busy; start SHALL be ignored in every other state.
REQ-019 RD_CNT SHALL drive COUNT_ADDR, latch min(mem_data, MAX_ENTRIES) as N, and go to DONE if N=0, else to RD_Q with index i=0.
REQ-020 RD_Q SHALL drive QVAL_BASE+2*i and latch mem_data as q_cur.
REQ-021 RD_ID SHALL drive ID_BASE+2*i; if i=0 or q_cur > best_q (unsigned, strict), it SHALL load best_q=q_cur, best_id=mem_data, best_idx=i.
REQ-022 Ties SHALL keep the earliest index.
REQ-023 After RD_ID, i SHALL increment, with a transition to DONE when i+1=N and to RD_Q otherwise.
REQ-024 DONE SHALL assert done for exactly one cycle, set found=(N!=0), drop busy, and return to IDLE.
REQ-025 Latency SHALL be deterministic: with start sampled at edge T, done SHALL be high in cycle T+2+2N.
REQ-026 Address arithmetic SHALL be 11-bit modulo 2048.
REQ-027 In IDLE and DONE, mem_address SHALL be COUNT_ADDR.
REQ-028 best_* and found SHALL hold their values until the next accepted start.
REQ-029 The block SHALL never write memory; the memory wr_en is driven by another master.

Reset
REQ-030 nrst=0 SHALL asynchronously force IDLE and set busy, done, found, best_id, best_q, best_idx and the internal i, N and q_cur to 0, including in the middle of a scan.
REQ-031 After reset release, the first start SHALL be accepted no earlier than the first clock edge with nrst=1.

Structure
REQ-032 The memory address map (COUNT_ADDR, QVAL_BASE, ID_BASE, the other list bases and counts) and the FSM state enum SHALL live in a shared package used by this block and by the memory map.
REQ-033 The block SHALL be a single module with no sub-module.

Verification
REQ-034 neighborCount=4; qValue=0x0140, 0x0460, 0x0500, 0x0780; IDs=1, 3, 4, 6; start at T -> done at T+10, found=1, best_id=6, best_q=0x0780, best_idx=3.
REQ-035 neighborCount=0 -> done at T+2, found=0, best_*=0.
REQ-036 qValue=0x0500, 0x0500, 0x0100 with IDs 7, 8, 9 -> best_id=7, best_idx=0 (tie keeps the earliest entry).
REQ-037 neighborCount=200 -> N clamped to 64, done at T+130, and mem_address never exceeds QVAL_BASE+126 or ID_BASE+126.
REQ-038 start pulsed during RD_Q, then nrst pulsed low during a scan -> the second start has no effect; reset immediately zeroes all outputs and returns to IDLE, and the next start runs a full scan correctly.
